// File: rtl/line_rotator_pingpong.sv
// Ping-pong line buffer that rotates each active video line by a per-line cut offset
// (scramble) or undoes that rotation (descramble); blanking passes through unchanged.
module line_rotator_pingpong #(
    parameter int                    DATA_WIDTH     = 10,
    parameter int                    ACTIVE_SAMPLES = 1440,
    parameter int                    CUT_WIDTH      = 8,
    parameter int                    CUT_STEP       = 4,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE    = 'h200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  H,
    input  logic                  V,
    input  logic [CUT_WIDTH-1:0]  cut_position,
    input  logic                  cut_valid,
    input  logic                  mode,
    input  logic                  bypass,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  cut_request,
    output logic                  cut_miss,
    output logic                  line_error
);

    localparam int AW = $clog2(2 * ACTIVE_SAMPLES);
    localparam int IW = $clog2(ACTIVE_SAMPLES + 2);
    localparam logic [AW-1:0] AS_A = AW'(ACTIVE_SAMPLES);
    localparam logic [IW-1:0] AS_I = IW'(ACTIVE_SAMPLES);

    // Both banks share one array: bank b occupies [b*ACTIVE_SAMPLES, (b+1)*ACTIVE_SAMPLES).
    logic [DATA_WIDTH-1:0] mem [0:2*ACTIVE_SAMPLES-1];

    logic                  wr_bank_reg;
    logic [IW-1:0]         wr_idx_reg;
    logic [IW-1:0]         rd_idx_reg;
    logic                  in_window_reg;
    logic [1:0]            bank_valid_reg;
    logic [AW-1:0]         d_reg;
    logic                  mode_reg;

    logic [DATA_WIDTH-1:0] data_d1_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic                  active_d1_reg;
    logic                  bypass_d1_reg;
    logic                  rd_ok_d1_reg;
    logic                  valid_d1_reg;

    logic                  active;
    logic                  win_end;
    logic                  wr_full;
    logic                  wr_en;
    logic                  rd_in_range;
    logic                  rd_bank;
    logic [CUT_WIDTH-1:0]  cut_sel;
    logic [AW-1:0]         cut_prod;
    logic [AW-1:0]         d_next;
    logic [AW-1:0]         fwd_sum;
    logic [AW-1:0]         fwd_addr;
    logic [AW-1:0]         bwd_sum;
    logic [AW-1:0]         bwd_addr;
    logic [AW-1:0]         rd_addr;
    logic [AW-1:0]         mem_raddr;
    logic [AW-1:0]         mem_waddr;

    always_comb begin
        active      = !H && !V;
        win_end     = H && in_window_reg;
        wr_full     = (wr_idx_reg == AS_I);
        wr_en       = active && (wr_idx_reg < AS_I);
        rd_in_range = (rd_idx_reg < AS_I);
        rd_bank     = ~wr_bank_reg;

        // cut*CUT_STEP is below 2*ACTIVE_SAMPLES, so one subtract reduces it.
        cut_sel  = cut_valid ? cut_position : '0;
        cut_prod = AW'(cut_sel) * AW'(CUT_STEP);
        d_next   = (cut_prod >= AS_A) ? cut_prod - AS_A : cut_prod;

        fwd_sum  = AW'(rd_idx_reg) + d_reg;
        fwd_addr = (fwd_sum >= AS_A) ? fwd_sum - AS_A : fwd_sum;
        bwd_sum  = AW'(rd_idx_reg) + AS_A - d_reg;
        bwd_addr = (bwd_sum >= AS_A) ? bwd_sum - AS_A : bwd_sum;

        rd_addr = '0;
        if (rd_in_range) begin
            if (!mode_reg)
                rd_addr = fwd_addr;
            else if (d_reg == '0)
                rd_addr = AW'(rd_idx_reg);
            else
                rd_addr = bwd_addr;
        end

        mem_raddr = rd_bank ? rd_addr + AS_A : rd_addr;
        mem_waddr = wr_bank_reg ? AW'(wr_idx_reg) + AS_A : AW'(wr_idx_reg);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[mem_waddr] <= data_in;
        rd_data_reg <= mem[mem_raddr];
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank_valid
            always_ff @(posedge clk) begin
                if (reset)
                    bank_valid_reg[gi] <= 1'b0;
                else if (win_end && (wr_bank_reg == 1'(gi)))
                    bank_valid_reg[gi] <= wr_full;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_reg   <= 1'b0;
            wr_idx_reg    <= '0;
            rd_idx_reg    <= '0;
            in_window_reg <= 1'b0;
            d_reg         <= '0;
            mode_reg      <= 1'b0;
            cut_request   <= 1'b0;
            cut_miss      <= 1'b0;
            line_error    <= 1'b0;
        end else begin
            cut_request <= win_end;
            if (win_end) begin
                wr_bank_reg   <= ~wr_bank_reg;
                wr_idx_reg    <= '0;
                rd_idx_reg    <= '0;
                in_window_reg <= 1'b0;
                d_reg         <= d_next;
                mode_reg      <= mode;
                if (!cut_valid)
                    cut_miss <= 1'b1;
                if (!wr_full)
                    line_error <= 1'b1;
            end else if (active) begin
                in_window_reg <= 1'b1;
                // Saturate one past full so an overlong window stays distinguishable.
                if (wr_idx_reg != AS_I + 1'b1)
                    wr_idx_reg <= wr_idx_reg + 1'b1;
                if (rd_idx_reg != AS_I + 1'b1)
                    rd_idx_reg <= rd_idx_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_d1_reg   <= '0;
            active_d1_reg <= 1'b0;
            bypass_d1_reg <= 1'b0;
            rd_ok_d1_reg  <= 1'b0;
            valid_d1_reg  <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
        end else begin
            data_d1_reg   <= data_in;
            active_d1_reg <= active;
            bypass_d1_reg <= bypass;
            rd_ok_d1_reg  <= bank_valid_reg[rd_bank] && rd_in_range;
            valid_d1_reg  <= 1'b1;
            data_valid    <= valid_d1_reg;
            if (bypass_d1_reg || !active_d1_reg)
                data_out <= data_d1_reg;
            else if (rd_ok_d1_reg)
                data_out <= rd_data_reg;
            else
                data_out <= BLANK_VALUE;
        end
    end

endmodule

// File: tb/tb_line_rotator_pingpong.sv
// Directed bench for line_rotator_pingpong: ramp/pattern lines with hand-derived
// rotations, blanking pass-through, cut miss, short window, bypass and mid-line reset.
module tb_line_rotator_pingpong;

    localparam int AS = 1440;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data_in = '0;
    logic       H = 1'b1;
    logic       V = 1'b0;
    logic [7:0] cut_position = '0;
    logic       cut_valid = 1'b0;
    logic       mode = 1'b0;
    logic       bypass = 1'b0;
    logic [9:0] data_out;
    logic       data_valid;
    logic       cut_request;
    logic       cut_miss;
    logic       line_error;

    always #5 clk = ~clk;

    line_rotator_pingpong dut (
        .clk(clk), .reset(reset), .data_in(data_in), .H(H), .V(V),
        .cut_position(cut_position), .cut_valid(cut_valid), .mode(mode), .bypass(bypass),
        .data_out(data_out), .data_valid(data_valid), .cut_request(cut_request),
        .cut_miss(cut_miss), .line_error(line_error)
    );

    // obs[j+1] holds the output produced for the input driven by call j of drv.
    logic [9:0] obs[$];
    logic       vobs[$];
    logic       creq[$];
    int n_checks = 0;
    int n_pass = 0;
    logic [9:0] bv [4] = '{10'h3FF, 10'h000, 10'h000, 10'h2D8};

    function automatic logic [9:0] pat_val(input int pat, input int i);
        return (pat == 0) ? 10'(i) : 10'(i * 3 + 7);
    endfunction

    task automatic drv(input logic [9:0] d, input logic h, input logic v);
        data_in = d; H = h; V = v;
        @(posedge clk); #1;
        obs.push_back(data_out);
        vobs.push_back(data_valid);
        creq.push_back(cut_request);
    endtask

    // 4 leading blanks, n active samples, then 2 trailing blanks; the window ends
    // on the first trailing blank, where the given cut/mode are presented.
    task automatic send_line(input int n, input int pat, input logic [7:0] cut, input logic cv,
                             input logic md, input logic byp, output int first, output int wend);
        bypass = byp;
        for (int i = 0; i < 4; i++) drv(bv[i], 1'b1, 1'b0);
        first = obs.size();
        for (int i = 0; i < n; i++) drv(pat_val(pat, i), 1'b0, 1'b0);
        cut_position = cut; cut_valid = cv; mode = md;
        wend = obs.size();
        drv(bv[0], 1'b1, 1'b0);
        drv(bv[3], 1'b1, 1'b0);
        cut_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drv(10'h155, 1'b0, 1'b0);
        cut_valid = 1'b0;
        drv(10'h0AA, 1'b1, 1'b0);
        drv(10'h3FF, 1'b1, 1'b0);
        n_checks++; if (data_out !== 10'h000) $display("FAIL reset_data_out got %0h want 0", data_out); else n_pass++;
        n_checks++; if (data_valid !== 1'b0) $display("FAIL reset_data_valid got %0b want 0", data_valid); else n_pass++;
        n_checks++; if (cut_request !== 1'b0) $display("FAIL reset_cut_request got %0b want 0", cut_request); else n_pass++;
        n_checks++; if (cut_miss !== 1'b0 || line_error !== 1'b0)
            $display("FAIL reset_sticky got miss=%0b err=%0b want 0 0", cut_miss, line_error); else n_pass++;
        reset = 1'b0;
        drv(bv[0], 1'b1, 1'b0);
        n_checks++; if (data_valid !== 1'b0) $display("FAIL valid_first_cycle got %0b want 0", data_valid); else n_pass++;
        drv(bv[0], 1'b1, 1'b0);
        n_checks++; if (data_valid !== 1'b1) $display("FAIL valid_second_cycle got %0b want 1", data_valid); else n_pass++;
    endtask

    task automatic test_first_window_blank();
        int first, wend, bad, bk;
        logic [9:0] ba;
        send_line(AS, 0, 8'd3, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0;
        for (int k = 0; k < AS; k++)
            if (obs[first + k + 1] !== 10'h200) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; end
                bad++;
            end
        n_checks++; if (bad != 0) $display("FAIL first_window_blank %0d wrong, k=%0d got %0h want 200", bad, bk, ba); else n_pass++;
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (obs[first - 4 + i + 1] !== bv[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL blank_passthrough %0d wrong, got %0h want %0h", bad, obs[first - 2], bv[1]); else n_pass++;
        n_checks++; if (creq[wend] !== 1'b1 || creq[wend - 1] !== 1'b0 || creq[wend + 1] !== 1'b0)
            $display("FAIL cut_request_pulse got %0b%0b%0b want 010", creq[wend - 1], creq[wend], creq[wend + 1]); else n_pass++;
        n_checks++; if (cut_miss !== 1'b0 || line_error !== 1'b0)
            $display("FAIL sticky_after_good_line got miss=%0b err=%0b want 0 0", cut_miss, line_error); else n_pass++;
    endtask

    task automatic test_rotate_scramble();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        send_line(AS, 0, 8'd255, 1'b1, 1'b1, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = 0; k < AS; k++) begin
            ex = 10'((k + 12) % AS);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL scramble_cut3 %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
        n_checks++; if (vobs[first + 1] !== 1'b1) $display("FAIL data_valid_active got %0b want 1", vobs[first + 1]); else n_pass++;
    endtask

    task automatic test_descramble_max();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        send_line(AS, 1, 8'd200, 1'b0, 1'b0, 1'b0, first, wend);
        n_checks++; if (obs[first + 1] !== 10'd420) $display("FAIL descramble_start got %0d want 420", obs[first + 1]); else n_pass++;
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = 0; k < AS; k++) begin
            ex = 10'((k + 420) % AS);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL descramble_cut255 %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
        n_checks++; if (cut_miss !== 1'b1) $display("FAIL cut_miss_set got %0b want 1", cut_miss); else n_pass++;
    endtask

    task automatic test_cut_miss();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        send_line(AS - 1, 0, 8'd0, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = 0; k < AS - 1; k++) begin
            ex = pat_val(1, k);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL miss_rotation0 %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
        n_checks++; if (cut_miss !== 1'b1) $display("FAIL cut_miss_sticky got %0b want 1", cut_miss); else n_pass++;
        n_checks++; if (line_error !== 1'b1) $display("FAIL line_error_short got %0b want 1", line_error); else n_pass++;
    endtask

    task automatic test_line_error();
        int first, wend, bad, bk;
        logic [9:0] ba;
        send_line(AS, 0, 8'd0, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0;
        for (int k = 0; k < AS; k++)
            if (obs[first + k + 1] !== 10'h200) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; end
                bad++;
            end
        n_checks++; if (bad != 0) $display("FAIL short_line_blank %0d wrong, k=%0d got %0h want 200", bad, bk, ba); else n_pass++;
    endtask

    task automatic test_bypass();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        send_line(AS, 1, 8'd0, 1'b1, 1'b0, 1'b1, first, wend);
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = -4; k < AS; k++) begin
            ex = (k < 0) ? bv[k + 4] : pat_val(1, k);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL bypass_passthrough %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        send_line(AS, 0, 8'd0, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = 0; k < AS; k++) begin
            ex = pat_val(1, k);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL write_during_bypass %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
    endtask

    task automatic test_reset_midline();
        int first, wend, bad, bk;
        logic [9:0] ba, be, ex;
        for (int i = 0; i < 4; i++) drv(bv[i], 1'b1, 1'b0);
        for (int i = 0; i < 700; i++) drv(pat_val(0, i), 1'b0, 1'b0);
        reset = 1'b1;
        drv(10'h155, 1'b0, 1'b0);
        n_checks++; if (data_out !== 10'h000 || data_valid !== 1'b0)
            $display("FAIL midline_reset_out got %0h/%0b want 0/0", data_out, data_valid); else n_pass++;
        cut_valid = 1'b0;
        drv(10'h0AA, 1'b1, 1'b0);
        reset = 1'b0;
        drv(bv[0], 1'b1, 1'b0);
        n_checks++; if (cut_miss !== 1'b0 || line_error !== 1'b0 || cut_request !== 1'b0)
            $display("FAIL midline_reset_flags got miss=%0b err=%0b req=%0b want 0 0 0", cut_miss, line_error, cut_request); else n_pass++;
        send_line(AS, 0, 8'd3, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0;
        for (int k = 0; k < AS; k++)
            if (obs[first + k + 1] !== 10'h200) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; end
                bad++;
            end
        n_checks++; if (bad != 0) $display("FAIL after_reset_blank %0d wrong, k=%0d got %0h want 200", bad, bk, ba); else n_pass++;
        send_line(AS, 1, 8'd0, 1'b1, 1'b0, 1'b0, first, wend);
        bad = 0; bk = 0; ba = '0; be = '0;
        for (int k = 0; k < AS; k++) begin
            ex = 10'((k + 12) % AS);
            if (obs[first + k + 1] !== ex) begin
                if (bad == 0) begin bk = k; ba = obs[first + k + 1]; be = ex; end
                bad++;
            end
        end
        n_checks++; if (bad != 0) $display("FAIL recovery_cut3 %0d wrong, k=%0d got %0d want %0d", bad, bk, ba, be); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_window_blank();
        test_rotate_scramble();
        test_descramble_max();
        test_cut_miss();
        test_line_error();
        test_bypass();
        test_back_to_back();
        test_reset_midline();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_rotator_pingpong.md
LINE_ROTATOR_PINGPONG -- requirements
Module: line_rotator_pingpong

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, meaning BT.656 sample width.
REQ-002 SHALL have parameter ACTIVE_SAMPLES, default 1440, meaning active samples per line (Cb Y Cr Y).
REQ-003 SHALL have parameter CUT_WIDTH, default 8, meaning cut_position width.
REQ-004 SHALL have parameter CUT_STEP, default 4, meaning samples per cut unit; constraint (2^CUT_WIDTH-1)*CUT_STEP < 2*ACTIVE_SAMPLES.
REQ-005 SHALL have parameter BLANK_VALUE, default 10'h200, meaning the sample emitted for an unwritten or invalid line.
REQ-006 clk  input  1  sole clock, all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 data_in  input  DATA_WIDTH  BT.656 sample stream.
REQ-009 H  input  1  horizontal blanking flag from sync_parser.
REQ-010 V  input  1  vertical blanking flag from sync_parser.
REQ-011 cut_position  input  CUT_WIDTH  rotation amount from drbg_consumer.
REQ-012 cut_valid  input  1  cut_position holds a fresh value.
REQ-013 mode  input  1  0 = scramble, 1 = descramble.
REQ-014 bypass  input  1  1 = pass data_in through unrotated.
REQ-015 data_out  output  DATA_WIDTH  processed stream.
REQ-016 data_valid  output  1  data_out carries a defined sample.
REQ-017 cut_request  output  1  one-cycle pulse requesting the next cut.
REQ-018 cut_miss  output  1  sticky: a line was processed without a fresh cut.
REQ-019 line_error  output  1  sticky: an active window length differed from ACTIVE_SAMPLES.

Function
REQ-020 An active sample SHALL be a cycle with H=0 and V=0; a window SHALL end on the first cycle with H=1 after an active sample.
REQ-021 Two banks of ACTIVE_SAMPLES words SHALL be kept; active samples SHALL be written to the write bank at wr_idx, starting at 0 and incrementing per active sample.
REQ-022 Writes with wr_idx >= ACTIVE_SAMPLES SHALL be dropped, and the bank SHALL be marked invalid.
REQ-023 At window end: banks SHALL swap, wr_idx SHALL clear, and the just-written bank SHALL be marked valid iff exactly ACTIVE_SAMPLES were written; otherwise line_error SHALL set.
REQ-024 At window end, cut_position SHALL be latched if cut_valid=1; if cut_valid=0, 0 SHALL be latched and cut_miss SHALL set.
REQ-025 cut_request SHALL pulse in the cycle after each window end.
REQ-026 Offset SHALL be d = cut*CUT_STEP reduced modulo ACTIVE_SAMPLES by one conditional subtract.
REQ-027 The read address SHALL be (rd_idx + d) mod ACTIVE_SAMPLES for mode=0.
REQ-028 The read address SHALL be (rd_idx + ACTIVE_SAMPLES - d) mod ACTIVE_SAMPLES for mode=1, and rd_idx for d=0.
REQ-029 mode SHALL be sampled at window end together with the cut.
REQ-030 During the next active window, rd_idx SHALL count active samples from 0; for an invalid bank or rd_idx >= ACTIVE_SAMPLES, BLANK_VALUE SHALL be output.
REQ-031 Non-active samples (EAV/SAV, ancillary, blanking) SHALL pass through unchanged.
REQ-032 Latency SHALL be exactly 2 cycles for every sample; active video SHALL be additionally delayed by one line.
REQ-033 bypass=1 SHALL output data_in with the same 2-cycle latency, while bank writes continue.
REQ-034 data_valid SHALL be 0 for 2 cycles after reset release, then 1.
REQ-035 A simultaneous window end and write (H rising) SHALL swap after the last write, so no sample is lost.

Reset
REQ-036 Reset SHALL clear data_out to 0, data_valid, cut_request, cut_miss, line_error, wr_idx, rd_idx, and the latched cut.
REQ-037 Reset SHALL select bank 0 for writing and mark both banks invalid.
REQ-038 Reset asserted mid-line SHALL abort that line, and the first active window after release SHALL output BLANK_VALUE.
REQ-039 Reset SHALL win over a simultaneous window end or cut_valid.

Verification
REQ-040 Ramp line 0..1439, then a second line, cut=3, mode=0 -> second window outputs 12,13,...,1439,0..11.
REQ-041 Scramble instance feeding descramble instance, same cut sequence -> output equals input delayed two lines plus 4 cycles.
REQ-042 cut_valid=0 at window end -> rotation 0 and cut_miss=1 until reset.
REQ-043 Window of 1439 samples -> line_error=1 and the next window outputs all BLANK_VALUE.
REQ-044 Max cut 255*4=1020, mode=1 -> read address starts at 420 and wraps correctly.
REQ-045 bypass=1 with a 10-frame file stream -> output file equals input shifted by 2 samples.
